// File: rtl/ffe_sched.sv
// rtl/ffe_sched.sv - FFE sample scheduler: sample FIFO, one load strobe per 4-cycle slot,
// shadow/active tap banks with slot-aligned commit. Optional FFE_SCHED_STATS_EN adds stat_underrun.
module ffe_sched #(
  parameter int WIDTH      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          ffe_load_sig,
  output logic [WIDTH-1:0]              ffe_in_data,
  input  logic                          cfg_we,
  input  logic [1:0]                    cfg_addr,
  input  logic [WIDTH-1:0]              cfg_wdata,
  input  logic                          cfg_commit,
  output logic                          cfg_busy,
  output logic [4*WIDTH-1:0]            taps_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef FFE_SCHED_STATS_EN
  ,
  output logic [15:0]                   stat_underrun
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [4*WIDTH-1:0] TAP_RST =
    {WIDTH'(-10), WIDTH'(10), WIDTH'(-16), WIDTH'(32)};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [4*WIDTH-1:0] shadow;

  logic full, empty, push, pop, boundary, underrun;

  assign full     = (fifo_level == LW'(FIFO_DEPTH));
  assign empty    = (fifo_level == '0);
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  // A slot boundary is any idle edge or the wrap of the running phase.
  assign boundary = (state_q == IDLE) || (phase_q == 2'd0);
  assign pop      = boundary && !empty;
  assign underrun = (state_q == RUN) && (phase_q == 2'd0) && empty;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: begin
        phase_d = 2'd0;
        if (pop) begin
          state_d = RUN;
          phase_d = 2'd1;
        end
      end
      RUN: begin
        phase_d = phase_q + 2'd1;
        if (underrun) begin
          state_d = IDLE;
          phase_d = 2'd0;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= 2'd0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      ffe_load_sig <= 1'b0;
      ffe_in_data  <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      ffe_load_sig <= pop;
      if (pop) begin
        ffe_in_data <= mem[rd_ptr];
        rd_ptr      <= rd_ptr + AW'(1);
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow   <= TAP_RST;
      taps_out <= TAP_RST;
      cfg_busy <= 1'b0;
    end else begin
      // Shadow is frozen while a commit waits so the committed set stays coherent.
      if (cfg_we && !cfg_busy) begin
        for (int i = 0; i < 4; i++) begin
          if (cfg_addr == 2'(i)) shadow[i*WIDTH +: WIDTH] <= cfg_wdata;
        end
      end
      if (cfg_busy && boundary) begin
        taps_out <= shadow;
        cfg_busy <= 1'b0;
      end else if (cfg_commit && !cfg_busy) begin
        cfg_busy <= 1'b1;
      end
    end
  end

`ifdef FFE_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_underrun <= '0;
    end else if (underrun && stat_underrun != 16'hFFFF) begin
      stat_underrun <= stat_underrun + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ffe_sched.sv
// tb/tb_ffe_sched.sv - directed and random checks of ffe_sched against a queue-based slot model.
module tb_ffe_sched;
  localparam int W = 12;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, ffe_load_sig, cfg_we, cfg_commit, cfg_busy;
  logic [W-1:0] in_data, ffe_in_data, cfg_wdata;
  logic [1:0]   cfg_addr;
  logic [4*W-1:0] taps_out;
  logic [2:0]   fifo_level;
`ifdef FFE_SCHED_STATS_EN
  logic [15:0]  stat_underrun;
`endif

  ffe_sched #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ffe_load_sig(ffe_load_sig), .ffe_in_data(ffe_in_data), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
    .cfg_busy(cfg_busy), .taps_out(taps_out), .fifo_level(fifo_level)
`ifdef FFE_SCHED_STATS_EN
    , .stat_underrun(stat_underrun)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Model: pending samples, whether a slot train is running, edges left until its next boundary.
  logic [W-1:0] mq[$];
  bit           m_run;
  int           m_wait;
  logic [W-1:0] m_shadow[4];
  logic [W-1:0] m_active[4];
  bit           m_busy;
  bit           m_load;
  logic [W-1:0] m_data;
  int           m_under;
  int           loads;
  int           max_level;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4*W-1:0] pack_taps();
    logic [4*W-1:0] r;
    for (int i = 0; i < 4; i++) r[i*W +: W] = m_active[i];
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_run = 0; m_wait = 0; m_busy = 0; m_load = 0; m_data = '0; m_under = 0;
    m_shadow[0] = 12'h020; m_shadow[1] = 12'hFF0; m_shadow[2] = 12'h00A; m_shadow[3] = 12'hFF6;
    m_active = m_shadow;
  endtask

  task automatic compare_all();
    check("load", {63'd0, ffe_load_sig}, {63'd0, m_load});
    check("data", {52'd0, ffe_in_data}, {52'd0, m_data});
    check("level", {61'd0, fifo_level}, 64'(mq.size()));
    check("in_ready", {63'd0, in_ready}, {63'd0, (mq.size() != D) && !rst});
    check("busy", {63'd0, cfg_busy}, {63'd0, m_busy});
    check("taps", {16'd0, taps_out}, {16'd0, pack_taps()});
`ifdef FFE_SCHED_STATS_EN
    check("stat_underrun", {48'd0, stat_underrun}, 64'(m_under));
`endif
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
  endtask

  task automatic model_edge(input bit v, input logic [W-1:0] d, input bit we,
                            input logic [1:0] a, input logic [W-1:0] wd, input bit cm);
    bit boundary, full, busy_pre;
    boundary = !m_run || (m_wait == 0);
    full     = (mq.size() == D);
    busy_pre = m_busy;
    if (boundary && m_run && mq.size() == 0 && m_under < 65535) m_under++;
    if (boundary && mq.size() > 0) begin
      m_data = mq.pop_front();
      m_load = 1; m_run = 1; m_wait = 3;
      loads++;
    end else begin
      m_load = 0;
      if (boundary) m_run = 0;
      else m_wait--;
    end
    if (v && !full) mq.push_back(d);
    if (busy_pre && boundary) begin
      m_active = m_shadow;
      m_busy = 0;
    end else if (cm && !busy_pre) begin
      m_busy = 1;
    end
    if (we && !busy_pre) m_shadow[a] = wd;
  endtask

  task automatic step(input bit v, input logic [W-1:0] d, input bit we,
                      input logic [1:0] a, input logic [W-1:0] wd, input bit cm);
    in_valid = v; in_data = d; cfg_we = we; cfg_addr = a; cfg_wdata = wd; cfg_commit = cm;
    @(posedge clk);
    model_edge(v, d, we, a, wd, cm);
    #1;
    compare_all();
  endtask

  task automatic idle_step();
    step(0, '0, 0, 2'd0, '0, 0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1;
    in_valid = 1; in_data = 12'hBAD; cfg_we = 1; cfg_addr = 2'd2; cfg_wdata = 12'h555; cfg_commit = 1;
    repeat (cycles) @(posedge clk);
    model_reset();
    #1;
    compare_all();
    rst = 0;
    in_valid = 0; cfg_we = 0; cfg_commit = 0;
    #1;
    compare_all();
  endtask

  initial begin
    int n;
    rst = 1; in_valid = 0; in_data = '0; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 0;
    loads = 0; max_level = 0;
    model_reset();

    // Reset defaults
    do_reset(2);
    check("taps_default", {16'd0, taps_out}, 64'h0000_FF60_0AFF_0020);
    check("level_default", {61'd0, fifo_level}, 64'd0);

    // Three back-to-back samples, then underrun back to IDLE
    loads = 0;
    step(1, 12'h101, 0, 0, '0, 0);
    step(1, 12'h102, 0, 0, '0, 0);
    check("first_load", {63'd0, ffe_load_sig}, 64'd1);
    check("first_data", {52'd0, ffe_in_data}, 64'h101);
    step(1, 12'h103, 0, 0, '0, 0);
    repeat (14) idle_step();
    check("three_loads", 64'(loads), 64'd3);
    check("back_to_idle_level", {61'd0, fifo_level}, 64'd0);

    // Continuous supply fills the FIFO; every sample comes out in order
    loads = 0; max_level = 0;
    for (int i = 0; i < 80; i++) step(1, W'($urandom), 0, 0, '0, 0);
    check("max_level", 64'(max_level), 64'd4);
    check("slot_rate", 64'(loads), 64'd20);
    n = 0;
    while ((m_run || mq.size() > 0) && n < 40) begin idle_step(); n++; end
    check("drain_bound", 64'(n < 40), 64'd1);

    // Commit at phase 2 lands with the next load strobe; write while busy is dropped
    for (int i = 0; i < 6; i++) step(1, W'(12'h200 + i), 0, 0, '0, 0);
    n = 0;
    while (!(m_run && m_wait == 2) && n < 20) begin idle_step(); n++; end
    check("phase2_bound", 64'(n < 20), 64'd1);
    step(0, '0, 1, 2'd1, 12'h010, 1);
    check("busy_set", {63'd0, cfg_busy}, 64'd1);
    step(0, '0, 1, 2'd1, 12'h777, 0);
    check("busy_hold", {63'd0, cfg_busy}, 64'd1);
    idle_step();
    check("commit_load", {63'd0, ffe_load_sig}, 64'd1);
    check("commit_h1", {52'd0, taps_out[23:12]}, 64'h010);
    check("commit_clear", {63'd0, cfg_busy}, 64'd0);

    // Reset mid-slot with a commit pending and samples queued
    n = 0;
    while (!(m_run && m_wait == 3) && n < 20) begin step(1, W'($urandom), 0, 0, '0, 0); n++; end
    step(1, 12'h0AA, 1, 2'd0, 12'h0AA, 1);
    step(1, 12'h0AB, 0, 0, '0, 0);
    check("pre_reset_busy", {63'd0, cfg_busy}, 64'd1);
    do_reset(1);
    check("post_reset_level", {61'd0, fifo_level}, 64'd0);
    check("post_reset_taps", {16'd0, taps_out}, 64'h0000_FF60_0AFF_0020);

    // Double commit in IDLE, then same-cycle write+commit
    step(0, '0, 1, 2'd0, 12'h055, 0);
    step(0, '0, 0, 0, '0, 1);
    step(0, '0, 0, 0, '0, 1);
    check("second_commit_ignored", {63'd0, cfg_busy}, 64'd0);
    check("h0_applied", {52'd0, taps_out[11:0]}, 64'h055);
    step(0, '0, 1, 2'd3, 12'h123, 1);
    idle_step();
    check("same_cycle_h3", {52'd0, taps_out[47:36]}, 64'h123);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(9) < 6), W'($urandom), ($urandom_range(9) < 2),
           2'($urandom), W'($urandom), ($urandom_range(9) < 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
